// File: rtl/mux_demux_sched_pkg.sv
// rtl/mux_demux_sched_pkg.sv - shared types and constants for the two-lane mux/demux scheduler
package mux_demux_sched_pkg;
  localparam int NUM_LANES = 2;
  localparam int PERF_W    = 32;

  typedef logic                 lane_idx_t;
  typedef logic [NUM_LANES-1:0] lane_vec_t;
endpackage

// File: rtl/mux_demux_sched_2_if.sv
// rtl/mux_demux_sched_2_if.sv - lane handshakes plus shared mux/demux path signals
interface mux_demux_sched_2_if #(
  parameter int ID    = 1,
  parameter int WIDTH = 2
);
  logic [1:0][WIDTH-1:0] in_data;
  logic [1:0]            in_valid;
  logic [1:0]            in_ready;
  logic [1:0][WIDTH-1:0] out_data;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;
  logic [1:0][WIDTH-1:0] mux_inp;
  logic                  mux_sel;
  logic [1:0][WIDTH-1:0] demux_outp;
  logic [31:0]           mux_id;

  modport master (
    output in_data, in_valid, out_ready, demux_outp,
    input  in_ready, out_data, out_valid, mux_inp, mux_sel, mux_id
  );

  modport slave (
    input  in_data, in_valid, out_ready, demux_outp,
    output in_ready, out_data, out_valid, mux_inp, mux_sel, mux_id
  );
endinterface

// File: rtl/mux_demux_sched_2_rr_arbiter.sv
// rtl/mux_demux_sched_2_rr_arbiter.sv - two-lane round-robin arbiter, ties go to the lane not granted last
module rr_arbiter_2
  import mux_demux_sched_pkg::*;
(
  input  lane_vec_t elig,
  input  lane_idx_t last_grant,
  output lane_vec_t grant,
  output lane_idx_t grant_idx
);
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    unique case (elig)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mux_demux_sched_2.sv
// rtl/mux_demux_sched_2.sv - time-multiplexes two valid/ready lanes over one shared mux/demux path
// Optional perf counters: define MUX_DEMUX_SCHED_PERF_EN.
module mux_demux_sched_2
  import mux_demux_sched_pkg::*;
#(
  parameter int ID    = 1,
  parameter int WIDTH = 2
) (
  input logic                clock,
  input logic                reset,
  mux_demux_sched_2_if.slave bus
`ifdef MUX_DEMUX_SCHED_PERF_EN
  ,
  output logic [1:0][PERF_W-1:0] perf_grants,
  output logic [PERF_W-1:0]      perf_stall
`endif
);
  logic [1:0][WIDTH-1:0] hold_data;
  lane_vec_t             hold_valid;
  logic [1:0][WIDTH-1:0] out_data;
  lane_vec_t             out_valid;
  lane_idx_t             last_grant;
  lane_vec_t             elig;
  lane_vec_t             grant;
  lane_idx_t             grant_idx;
  lane_vec_t             accept;

  // A lane is only worth granting if its output register can take the result now.
  assign elig   = hold_valid & (~out_valid | bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;

  rr_arbiter_2 u_arb (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign bus.in_ready  = {NUM_LANES{~reset}} & (~hold_valid | grant);
  assign bus.mux_inp   = hold_data;
  assign bus.mux_sel   = grant_idx;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.mux_id    = 32'(ID);

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      last_grant <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept[i]) begin
          hold_data[i]  <= bus.in_data[i];
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
        if (grant[i]) begin
          out_data[i]  <= bus.demux_outp[i];
          out_valid[i] <= 1'b1;
        end else if (out_valid[i] && bus.out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (|grant) last_grant <= grant_idx;
    end
  end

`ifdef MUX_DEMUX_SCHED_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (grant[i]) perf_grants[i] <= perf_grants[i] + 1'b1;
      end
      if (|(hold_valid & ~grant)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: doc/mux_demux_sched_2.md
# mux_demux_sched_2

Two-lane time-multiplexing scheduler that sits directly upstream and downstream of the shared 2-way mux→demux path. It buffers operands from two independent valid/ready lanes and drives the shared path's packed input and select, one lane per cycle, round-robin. It captures the selected lane's result from the demux output into a per-lane output register with its own valid/ready handshake. Two producers share one datapath without either starving.

## Interface
- `ID`, default 1: instance tag, forwarded unchanged to the shared path.
- `WIDTH`, default 2: data width per lane.
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_data` input [1:0][WIDTH-1:0]: operand per lane.
- `in_valid` input [1:0]: operand valid per lane.
- `in_ready` output [1:0]: lane can accept an operand this cycle.
- `out_data` output [1:0][WIDTH-1:0]: result per lane, registered.
- `out_valid` output [1:0]: result valid per lane.
- `out_ready` input [1:0]: consumer accepts result.
- `mux_inp` output [1:0][WIDTH-1:0]: packed input to the shared path. Lane i's hold register drives slot i.
- `mux_sel` output 1: select to the shared path.
- `demux_outp` input [1:0][WIDTH-1:0]: shared path output. Only slot `mux_sel` is meaningful.

## Operation
- Per-lane state: a hold register (`hold_data`, `hold_valid`) and an output register (`out_data`, `out_valid`). Global state: `last_grant` (1 bit).
- Input handshake: transfer on lane i when `in_valid[i] & in_ready[i]`.
  - `in_ready[i] = ~reset & (~hold_valid[i] | grant[i])`.
  - A hold register that is drained and refilled in the same cycle stays full.
- Eligibility: `elig[i] = hold_valid[i] & (~out_valid[i] | out_ready[i])`.
- Arbitration (combinational, in the sub-module):
  - Only one lane eligible: that lane is granted.
  - Both eligible: the lane != `last_grant` is granted.
  - Neither eligible: no grant.
- `mux_sel`: the granted lane's index; when there is no grant, `mux_sel = last_grant`.
- On a grant to lane i:
  - `out_data[i] <= demux_outp[i]`, `out_valid[i] <= 1`.
  - `hold_valid[i]` is cleared unless it is refilled in the same cycle.
  - `last_grant <= i`.
- Output handshake: when `out_valid[i] & out_ready[i]` with no grant to lane i, `out_valid[i] <= 0`. When both happen, the output register reloads and stays valid.
- Data is never modified. Results appear in per-lane FIFO order, with at most 2 in flight per lane (hold + out).
- Reset, including mid-operation:
  - Cleared: `hold_valid`, `out_valid`. `out_data`, `hold_data` ← 0. `last_grant` ← 1, so lane 0 wins the first tie.
  - In-flight data is discarded. `in_ready` = 0 while `reset` is high.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `mux_inp`=0, `mux_sel`=1, `in_ready`=0 during reset and 1 in the first cycle after.
- Latency: operand accepted at edge N → hold valid in cycle N+1. Granted in N+1 if uncontended → `out_valid` in cycle N+2, a 2-cycle latency.
- Throughput: one result per cycle in aggregate; each lane gets at least one grant every 2 cycles under contention.
- The shared path is combinational. `demux_outp` must be settled within the grant cycle.
- No combinational path from `in_valid` to `in_ready`. `out_ready` reaches `in_ready` through eligibility.

## Configuration
- `MUX_DEMUX_SCHED_PERF_EN` defined: adds the following outputs, each 32 bits, wrapping, cleared on reset.
  - `perf_grants[1:0]`: grants per lane.
  - `perf_stall`: counts cycles where some `hold_valid[i]` is set but lane i is not granted.
- Undefined: these ports and counters are absent. The remaining behaviour is identical.

## Structure
- Package `mux_demux_sched_pkg`:
  - `NUM_LANES = 2`.
  - `typedef logic lane_idx_t`.
  - `typedef logic [NUM_LANES-1:0] lane_vec_t`.
  - Perf counter width constant `PERF_W = 32`.
- Sub-module `rr_arbiter_2`: inputs `elig`, `last_grant`; outputs `grant` (one-hot or zero) and `grant_idx`. Purely combinational.
- Top level instantiates `rr_arbiter_2` and holds all registers.

## Test plan
- Single lane 0: `in_data[0]`=2'b10 at cycle 1 with the shared path passing through → `mux_sel`=0 in cycle 2, `out_data[0]`=2'b10 and `out_valid[0]`=1 in cycle 3, `out_valid[1]`=0 throughout.
- Simultaneous first inputs, 2'b01 on lane 0 and 2'b11 on lane 1 → lane 0 granted in cycle 2 and lane 1 in cycle 3; outputs valid in cycles 3 and 4 respectively.
- Continuous `in_valid`=2'b11 with `out_ready`=2'b11 for 20 cycles → `mux_sel` alternates 0,1,0,1…; each lane gets 10 ±1 results, in order.
- Backpressure: `out_ready[1]`=0 with lane 1 full → lane 1 is never granted, `in_ready[1]`=0 after the hold register fills, lane 0 runs every cycle. Releasing `out_ready[1]` → lane 1 resumes with no lost or duplicated data.
- Reset asserted for 1 cycle with both lanes full → next cycle all valids are 0, `in_ready`=2'b11, `mux_sel`=1; the next tie is granted to lane 0.
- With `MUX_DEMUX_SCHED_PERF_EN`: rerun the backpressure scenario → `perf_grants[1]` stays frozen, `perf_stall` increments once per blocked cycle, and the counters read 0 after reset.
